// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states
// and the per-operation latency rule.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_ADC = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1011;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_SRA = 4'b1101;

    typedef enum logic {IDLE, EXEC} state_e;

    // Cycles from acceptance to done for a given op.
    function automatic int lat(input logic [3:0] op,
                               input int shamt,
                               input int width);
        int s;
        s = (shamt > width) ? width : shamt;
        if (op == OP_MUL)
            return width;
        if (op == OP_SHL || op == OP_SHR || op == OP_SRA)
            return (s < 1) ? 1 : s;
        return 1;
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath for shifts and shift-add multiply.
// Ports: load_i (accept edge), en_i (op in flight), op/a/b/shamt
// operands, last_o (final cycle), lo_o/hi_o results, cout_o.
module seq_alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             last_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             cout_o
);

    logic [3:0]       op_q, op_s;
    logic [WIDTH-1:0] mc_q, mc_s;
    logic [WIDTH-1:0] lo_q, lo_d, lo_s;
    logic [WIDTH-1:0] hi_q, hi_d, hi_s;
    logic [SHW-1:0]   rem_q, rem_d, rem_s;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic [WIDTH:0]   sum;
    logic             step;

    // The loading edge already performs the first step, so the
    // L edges k..k+L-1 complete exactly L steps before done.
    assign step = load_i || (en_i && cnt_q != '0);

    always_comb begin
        op_s  = load_i ? op_i : op_q;
        mc_s  = load_i ? a_i  : mc_q;
        lo_s  = load_i ? b_i  : lo_q;
        hi_s  = load_i ? '0   : hi_q;
        rem_s = rem_q;
        if (load_i)
            rem_s = (shamt_i > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt_i;
        lo_d   = lo_s;
        hi_d   = hi_s;
        rem_d  = rem_s;
        cout_d = load_i ? 1'b0 : cout_q;
        sum    = {1'b0, hi_s} + (lo_s[0] ? {1'b0, mc_s} : '0);
        if (op_s == OP_MUL) begin
            {hi_d, lo_d} = {sum, lo_s[WIDTH-1:1]};
        end else if (rem_s != '0) begin
            case (op_s)
                OP_SHL: begin
                    lo_d   = {lo_s[WIDTH-2:0], 1'b0};
                    cout_d = lo_s[WIDTH-1];
                    rem_d  = rem_s - SHW'(1);
                end
                OP_SHR: begin
                    lo_d   = {1'b0, lo_s[WIDTH-1:1]};
                    cout_d = lo_s[0];
                    rem_d  = rem_s - SHW'(1);
                end
                OP_SRA: begin
                    lo_d   = {lo_s[WIDTH-1], lo_s[WIDTH-1:1]};
                    cout_d = lo_s[0];
                    rem_d  = rem_s - SHW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = SHW'(lat(op_i, int'(shamt_i), WIDTH) - 1);
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - SHW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            mc_q   <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            if (load_i) begin
                op_q <= op_i;
                mc_q <= a_i;
            end
            if (step) begin
                lo_q   <= lo_d;
                hi_q   <= hi_d;
                rem_q  <= rem_d;
                cout_q <= cout_d;
            end
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == '0);
    assign lo_o   = lo_q;
    assign hi_o   = hi_q;
    assign cout_o = cout_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake and held flags.
// Ports: start/aluOp/A/B/shamt request, busy/done status,
// result/result_hi and Z/C/N/V flags.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       aluOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             Z,
    output logic             C,
    output logic             N,
    output logic             V
);

    localparam int M = WIDTH - 1;

    state_e           st_q, st_d;
    logic             accept;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cst_q;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
    logic             z_q, c_q, n_q, v_q;
    logic             z_d, c_d, n_d, v_d;
    logic [WIDTH:0]   sum;
    logic             it_last, it_cout;
    logic [WIDTH-1:0] it_lo, it_hi;

    assign accept = (st_q == IDLE) && start;
    assign busy   = (st_q == EXEC);
    assign done   = busy && it_last;

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE: if (start)   st_d = EXEC;
            EXEC: if (it_last) st_d = IDLE;
        endcase
    end

    seq_alu_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .en_i    (busy),
        .op_i    (aluOp),
        .a_i     (A),
        .b_i     (B),
        .shamt_i (shamt),
        .last_o  (it_last),
        .lo_o    (it_lo),
        .hi_o    (it_hi),
        .cout_o  (it_cout)
    );

    always_comb begin
        res_d = '0;
        hi_d  = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        sum   = '0;
        case (op_q)
            OP_ADD, OP_ADC: begin
                sum = {1'b0, a_q} + {1'b0, b_q};
                if (op_q == OP_ADC)
                    sum = sum + {{WIDTH{1'b0}}, cst_q};
                {c_d, res_d} = sum;
                v_d = (a_q[M] == b_q[M]) && (sum[M] != a_q[M]);
            end
            OP_SUB: begin
                // bit WIDTH of the extended difference is the borrow
                sum = {1'b0, a_q} - {1'b0, b_q};
                {c_d, res_d} = sum;
                v_d = (a_q[M] != b_q[M]) && (sum[M] != a_q[M]);
            end
            OP_NOR: res_d = ~(a_q | b_q);
            OP_AND: res_d = a_q & b_q;
            OP_OR:  res_d = a_q | b_q;
            OP_XOR: res_d = a_q ^ b_q;
            OP_MUL: begin
                res_d = it_lo;
                hi_d  = it_hi;
                c_d   = |it_hi;
            end
            OP_SHL, OP_SHR, OP_SRA: begin
                res_d = it_lo;
                c_d   = it_cout;
            end
            default: ;
        endcase
        z_d = (res_d == '0);
        n_d = res_d[M];
    end

    // Values are valid in the done cycle itself, then held.
    assign result    = done ? res_d : res_q;
    assign result_hi = done ? hi_d  : hi_q;
    assign Z         = done ? z_d   : z_q;
    assign C         = done ? c_d   : c_q;
    assign N         = done ? n_d   : n_q;
    assign V         = done ? v_d   : v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cst_q <= 1'b0;
            res_q <= '0;
            hi_q  <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            n_q   <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            st_q <= st_d;
            if (accept) begin
                op_q <= aluOp;
                a_q  <= A;
                b_q  <= B;
            end
            if (done) begin
                res_q <= res_d;
                hi_q  <= hi_d;
                z_q   <= z_d;
                c_q   <= c_d;
                n_q   <= n_d;
                v_q   <= v_d;
                if (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_ADC)
                    cst_q <= c_d;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu (WIDTH=8)
// against an arithmetic reference model.
module tb_seq_alu;

    localparam int W   = 8;
    localparam int SHW = $clog2(W) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [3:0]     aluOp;
    logic [W-1:0]   A, B;
    logic [SHW-1:0] shamt;
    logic           busy, done, Z, C, N, V;
    logic [W-1:0]   result, result_hi;

    int n_chk = 0;
    int n_err = 0;
    int cst = 0;
    int p_res = 0, p_hi = 0, p_z = 0, p_c = 0, p_n = 0, p_v = 0;
    int g_res, g_hi, g_c;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W), .SHW(SHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .aluOp     (aluOp),
        .A         (A),
        .B         (B),
        .shamt     (shamt),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .Z         (Z),
        .C         (C),
        .N         (N),
        .V         (V)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int op, a, b, sh, cin,
                                  output int r, hi, c, v, l);
        int sa, sb, ss, s, t;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        s  = (sh > W) ? W : sh;
        r = 0; hi = 0; c = 0; v = 0; l = 1;
        case (op)
            1: begin
                t = a + b; r = t & 255; c = t >> 8;
                ss = sa + sb; v = int'(ss > 127 || ss < -128);
            end
            2: begin
                r = (a - b) & 255; c = int'(a < b);
                ss = sa - sb; v = int'(ss > 127 || ss < -128);
            end
            3: r = ~(a | b) & 255;
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: begin
                t = a + b + cin; r = t & 255; c = t >> 8;
                ss = sa + sb + cin; v = int'(ss > 127 || ss < -128);
            end
            8: begin
                t = a * b; r = t & 255; hi = t >> 8;
                c = int'(hi != 0); l = W;
            end
            11: begin
                r = (b << s) & 255;
                c = (s == 0) ? 0 : ((b >> (W - s)) & 1);
                l = (s < 1) ? 1 : s;
            end
            12: begin
                r = b >> s;
                c = (s == 0) ? 0 : ((b >> (s - 1)) & 1);
                l = (s < 1) ? 1 : s;
            end
            13: begin
                r = (sb >>> s) & 255;
                c = (s == 0) ? 0 : ((sb >>> (s - 1)) & 1);
                l = (s < 1) ? 1 : s;
            end
            default: ;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge
    // of cycle k+L+1. pk: 0 none, -1 random, >0 fixed poke cycle.
    task automatic run_op(input int op, a, b, sh, pk);
        int r, hi, c, v, l, pj;
        model(op, a, b, sh, cst, r, hi, c, v, l);
        check("idle", 32'(busy), 0);
        start = 1'b1;
        aluOp = 4'(op);
        A     = 8'(a);
        B     = 8'(b);
        shamt = SHW'(sh);
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = 8'($urandom);
        B     = 8'($urandom);
        aluOp = 4'($urandom);
        shamt = SHW'($urandom);
        pj = (pk < 0) ? int'($urandom_range(1, l)) : pk;
        for (int j = 1; j <= l; j++) begin
            @(negedge clk);
            check("busy", 32'(busy), 1);
            check("done", 32'(done), 32'(j == l));
            if (j < l) begin
                check("hold_res", 32'(result), p_res);
            end else begin
                check("res", 32'(result), r);
                check("hi", 32'(result_hi), hi);
                check("Z", 32'(Z), 32'(r == 0));
                check("C", 32'(C), c);
                check("N", 32'(N), (r >> 7) & 1);
                check("V", 32'(V), v);
                g_res = int'(result);
                g_hi  = int'(result_hi);
                g_c   = int'(C);
            end
            start = (j == pj);
        end
        if (op == 1 || op == 2 || op == 7)
            cst = c;
        p_res = r; p_hi = hi; p_z = int'(r == 0);
        p_c = c; p_n = (r >> 7) & 1; p_v = v;
        @(negedge clk);
        start = 1'b0;
        check("post_busy", 32'(busy), 0);
        check("post_done", 32'(done), 0);
        check("post_res", 32'(result), p_res);
        check("post_hi", 32'(result_hi), p_hi);
    endtask

    task automatic reset_mid_mul(input int a, b);
        start = 1'b1;
        aluOp = 4'd8;
        A     = 8'(a);
        B     = 8'(b);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            check("rm_busy", 32'(busy), 1);
            check("rm_done", 32'(done), 0);
            if (j == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("rm_busy0", 32'(busy), 0);
        check("rm_res0", 32'(result), 0);
        check("rm_hi0", 32'(result_hi), 0);
        check("rm_flags0", 32'({Z, C, N, V}), 0);
        for (int j = 6; j <= 10; j++) begin
            @(negedge clk);
            check("rm_nodone", 32'(done), 0);
        end
        cst = 0;
        p_res = 0; p_hi = 0; p_z = 0; p_c = 0; p_n = 0; p_v = 0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        aluOp = '0;
        A     = '0;
        B     = '0;
        shamt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_res", 32'(result), 0);
        check("rst_hi", 32'(result_hi), 0);
        check("rst_flags", 32'({Z, C, N, V}), 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(1, 8'hF0, 8'h20, 0, 0);
        check("t1_add", g_res, 8'h10);
        run_op(2, 8'h10, 8'h20, 0, 0);
        check("t1_sub", g_res, 8'hF0);
        run_op(1, 8'hFF, 8'h01, 0, 0);
        run_op(7, 8'h00, 8'h00, 0, 0);
        check("t2_adc", g_res, 8'h01);
        run_op(7, 8'h7F, 8'h00, 0, 0);
        run_op(8, 8'h10, 8'h20, 0, 3);
        check("t3_mulhi", g_hi, 8'h02);
        run_op(11, 0, 8'h81, 1, 0);
        run_op(13, 0, 8'h80, 3, 0);
        check("t4_sra", g_res, 8'hF0);
        run_op(12, 0, 8'hFF, 12, 0);
        check("t4_shr_c", g_c, 1);
        run_op(1, 8'hFF, 8'h01, 0, 0);
        reset_mid_mul(8'hAB, 8'hCD);
        run_op(1, 8'h12, 8'h34, 0, 0);
        run_op(7, 8'h00, 8'h00, 0, 0);
        run_op(0, 8'h55, 8'h33, 0, 0);

        for (int i = 0; i < 200; i++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                   ($urandom_range(0, 1) == 1) ? -1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
